// File: rtl/l1i_assoc_cache.sv
// Read-only set-associative L1 instruction cache with per-set round-robin
// replacement, burst line refill and whole-cache invalidate.
module l1i_assoc_cache #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WAY_NUM    = 4,
  parameter int unsigned SET_NUM    = 64,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  core_req_val,
  input  logic [ADDR_WIDTH-1:0] core_req_addr,
  output logic                  core_req_ack,
  output logic [DATA_WIDTH-1:0] core_ack_data,
  input  logic                  inv_req,
  output logic                  mem_req_val,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_req_ack,
  input  logic                  mem_resp_val,
  input  logic [DATA_WIDTH-1:0] mem_resp_data
);

  localparam int unsigned OFF_W  = $clog2(DATA_WIDTH / 8);
  localparam int unsigned WSEL_W = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W  = $clog2(SET_NUM);
  localparam int unsigned TAG_W  = ADDR_WIDTH - OFF_W - WSEL_W - IDX_W;
  localparam int unsigned WAY_W  = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;
  localparam int unsigned LA_W   = ADDR_WIDTH - OFF_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, MREQ, FILL} state_e;

  state_e                  state_q;
  logic [LA_W-1:0]         addr_q;
  logic [WAY_W-1:0]        victim_q;
  logic [WSEL_W-1:0]       beat_q;
  logic                    inv_pend_q;
  logic                    mem_req_val_q;
  logic [ADDR_WIDTH-1:0]   mem_req_addr_q;
  logic [SET_NUM-1:0]      valid_q [WAY_NUM];
  logic [WAY_W-1:0]        ptr_q   [SET_NUM];
  logic [TAG_W-1:0]        tag_q   [WAY_NUM][SET_NUM];
  logic [DATA_WIDTH-1:0]   data_q  [WAY_NUM][SET_NUM][LINE_WORDS];

  logic [WSEL_W-1:0] wsel;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  ptr_nxt;
  logic              last_beat;

  // Byte-offset bits of the fetch address never select anything.
  generate
    if (OFF_W > 0) begin : g_off
      logic unused_off;
      assign unused_off = ^core_req_addr[OFF_W-1:0];
    end
  endgenerate

  assign wsel      = addr_q[WSEL_W-1:0];
  assign idx       = addr_q[WSEL_W +: IDX_W];
  assign tag       = addr_q[LA_W-1 -: TAG_W];
  assign last_beat = (beat_q == WSEL_W'(LINE_WORDS - 1));
  assign ptr_nxt   = (ptr_q[idx] == WAY_W'(WAY_NUM - 1)) ? '0 : ptr_q[idx] + 1'b1;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAY_NUM; w++) begin
      if (!hit && valid_q[w][idx] && (tag_q[w][idx] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Ack must land in the LOOKUP cycle itself, so it is decoded from state.
  assign core_req_ack  = (state_q == LOOKUP) && hit;
  assign core_ack_data = core_req_ack ? data_q[hit_way][idx][wsel] : '0;
  assign mem_req_val   = mem_req_val_q;
  assign mem_req_addr  = mem_req_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      victim_q       <= '0;
      beat_q         <= '0;
      inv_pend_q     <= 1'b0;
      mem_req_val_q  <= 1'b0;
      mem_req_addr_q <= '0;
      for (int unsigned w = 0; w < WAY_NUM; w++) valid_q[w] <= '0;
      for (int unsigned s = 0; s < SET_NUM; s++) ptr_q[s] <= '0;
    end else begin
      if (inv_req) inv_pend_q <= 1'b1;
      case (state_q)
        IDLE: begin
          // A same-cycle inv_req is serviced now rather than after a flag round-trip.
          if (inv_pend_q || inv_req) begin
            inv_pend_q <= 1'b0;
            for (int unsigned w = 0; w < WAY_NUM; w++) valid_q[w] <= '0;
            for (int unsigned s = 0; s < SET_NUM; s++) ptr_q[s] <= '0;
          end else if (core_req_val) begin
            addr_q  <= core_req_addr[ADDR_WIDTH-1:OFF_W];
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            state_q <= IDLE;
          end else begin
            victim_q       <= ptr_q[idx];
            mem_req_val_q  <= 1'b1;
            mem_req_addr_q <= {tag, idx, {(ADDR_WIDTH - TAG_W - IDX_W){1'b0}}};
            state_q        <= MREQ;
          end
        end
        MREQ: begin
          if (mem_req_ack) begin
            mem_req_val_q  <= 1'b0;
            mem_req_addr_q <= '0;
            beat_q         <= '0;
            state_q        <= FILL;
          end
        end
        FILL: begin
          if (mem_resp_val) begin
            beat_q <= beat_q + 1'b1;
            if (last_beat) begin
              valid_q[victim_q][idx] <= 1'b1;
              ptr_q[idx]             <= ptr_nxt;
              state_q                <= LOOKUP;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((state_q == FILL) && mem_resp_val) begin
      data_q[victim_q][idx][beat_q] <= mem_resp_data;
      if (last_beat) tag_q[victim_q][idx] <= tag;
    end
  end

endmodule

// File: tb/tb_l1i_assoc_cache.sv
// Directed bench for l1i_assoc_cache: cold miss, hits, round-robin replacement,
// invalidate, memory stalls and reset during a refill.
module tb_l1i_assoc_cache;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          core_req_val;
  logic [AW-1:0] core_req_addr;
  logic          core_req_ack;
  logic [DW-1:0] core_ack_data;
  logic          inv_req;
  logic          mem_req_val;
  logic [AW-1:0] mem_req_addr;
  logic          mem_req_ack;
  logic          mem_resp_val;
  logic [DW-1:0] mem_resp_data;

  int n_assert = 0;
  int n_fail   = 0;

  l1i_assoc_cache #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .WAY_NUM   (4),
    .SET_NUM   (64),
    .LINE_WORDS(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .core_req_val (core_req_val),
    .core_req_addr(core_req_addr),
    .core_req_ack (core_req_ack),
    .core_ack_data(core_ack_data),
    .inv_req      (inv_req),
    .mem_req_val  (mem_req_val),
    .mem_req_addr (mem_req_addr),
    .mem_req_ack  (mem_req_ack),
    .mem_resp_val (mem_resp_val),
    .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish before 200000");
    $fatal(1);
  end

  // Backing memory contents: each word is derived from its own byte address.
  function automatic logic [31:0] memval(input logic [31:0] wa);
    return {wa[15:0], ~wa[15:0]};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered and left in an IDLE cycle (at its negedge).
  task automatic fetch(input logic [31:0] a, input bit exp_hit, input int ack_dly,
                       input int gap, input int inv_beat, input bit inv_first,
                       input string tag);
    logic [31:0] line;
    logic [31:0] exp;
    bit stable_ok;
    bit quiet_ok;
    line = a & ~32'hF;
    exp  = memval(a & ~32'h3);
    check({tag, "_idle_ack"}, core_req_ack, 1'b0);
    core_req_addr = a;
    core_req_val  = 1'b1;
    if (inv_first) begin
      inv_req = 1'b1;
      tick();
      inv_req = 1'b0;
      check({tag, "_inv_hold"}, {core_req_ack, mem_req_val}, 2'b00);
    end
    tick();
    if (exp_hit) begin
      check({tag, "_hit_ack"}, core_req_ack, 1'b1);
      check({tag, "_hit_data"}, core_ack_data, exp);
      check({tag, "_hit_nomem"}, mem_req_val, 1'b0);
    end else begin
      check({tag, "_miss_noack"}, core_req_ack, 1'b0);
      tick();
      check({tag, "_mreq_val"}, mem_req_val, 1'b1);
      check({tag, "_mreq_addr"}, mem_req_addr, line);
      stable_ok = 1'b1;
      quiet_ok  = 1'b1;
      for (int i = 0; i < ack_dly; i++) begin
        mem_resp_val  = 1'b1;
        mem_resp_data = 32'hDEAD_BEEF;
        tick();
        stable_ok &= (mem_req_val === 1'b1) && (mem_req_addr === line);
        quiet_ok  &= (core_req_ack === 1'b0);
      end
      mem_resp_val = 1'b0;
      mem_req_ack  = 1'b1;
      tick();
      mem_req_ack = 1'b0;
      check({tag, "_mreq_drop"}, {mem_req_val, mem_req_addr}, 33'h0);
      for (int b = 0; b < 4; b++) begin
        for (int g = 0; g < gap; g++) begin
          quiet_ok &= (core_req_ack === 1'b0);
          tick();
        end
        quiet_ok &= (core_req_ack === 1'b0);
        mem_resp_val  = 1'b1;
        mem_resp_data = memval(line + 32'(4 * b));
        inv_req       = (b == inv_beat);
        tick();
        mem_resp_val = 1'b0;
        inv_req      = 1'b0;
      end
      check({tag, "_replay_ack"}, core_req_ack, 1'b1);
      check({tag, "_replay_data"}, core_ack_data, exp);
      check({tag, "_wait_noack"}, quiet_ok, 1'b1);
      if (ack_dly > 0) check({tag, "_addr_stable"}, stable_ok, 1'b1);
    end
    core_req_val = 1'b0;
    tick();
  endtask

  initial begin
    rst_n         = 1'b0;
    core_req_val  = 1'b0;
    core_req_addr = '0;
    inv_req       = 1'b0;
    mem_req_ack   = 1'b0;
    mem_resp_val  = 1'b0;
    mem_resp_data = '0;
    #1;
    check("rst_ack",   core_req_ack,  1'b0);
    check("rst_data",  core_ack_data, 32'h0);
    check("rst_mval",  mem_req_val,   1'b0);
    check("rst_maddr", mem_req_addr,  32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Cold miss then hits on the same line
    fetch(32'h0000_1004, 1'b0, 0, 0, -1, 1'b0, "cold");
    fetch(32'h0000_1000, 1'b1, 0, 0, -1, 1'b0, "hit0");
    fetch(32'h0000_100C, 1'b1, 0, 0, -1, 1'b0, "hit3");

    // Invalidate together with a request: serviced first, line then misses
    fetch(32'h0000_1008, 1'b0, 0, 0, -1, 1'b1, "invreq");
    // Lone invalidate pulse in IDLE resets the set pointers for the replacement run
    inv_req = 1'b1;
    tick();
    inv_req = 1'b0;

    // Five tags in set 0 fill ways 0,1,2,3 then evict way 0
    fetch(32'h0001_0000, 1'b0, 0, 0, -1, 1'b0, "rrA");
    fetch(32'h0001_0404, 1'b0, 0, 0, -1, 1'b0, "rrB");
    fetch(32'h0001_0808, 1'b0, 0, 0, -1, 1'b0, "rrC");
    fetch(32'h0001_0C0C, 1'b0, 0, 0, -1, 1'b0, "rrD");
    fetch(32'h0001_1000, 1'b0, 0, 0, -1, 1'b0, "rrE");
    fetch(32'h0001_0004, 1'b0, 0, 0, -1, 1'b0, "rrA_again");
    fetch(32'h0001_080C, 1'b1, 0, 0, -1, 1'b0, "rrC_hit");
    fetch(32'h0001_0C00, 1'b1, 0, 0, -1, 1'b0, "rrD_hit");
    fetch(32'h0001_1008, 1'b1, 0, 0, -1, 1'b0, "rrE_hit");
    fetch(32'h0001_0400, 1'b0, 0, 0, -1, 1'b0, "rrB_evicted");

    // Invalidate during a refill: current request still acked, then all lines gone
    fetch(32'h0002_0004, 1'b0, 0, 0, 2, 1'b0, "invfill");
    tick();
    fetch(32'h0002_0004, 1'b0, 0, 0, -1, 1'b0, "invfill_reread");
    fetch(32'h0001_1000, 1'b0, 0, 0, -1, 1'b0, "invfill_E_gone");

    // Memory stalls with stray beats during the request phase
    fetch(32'h0000_4A3C, 1'b0, 5, 3, -1, 1'b0, "stall");
    fetch(32'h0000_4A30, 1'b1, 0, 0, -1, 1'b0, "stall_w0");
    fetch(32'h0000_4A34, 1'b1, 0, 0, -1, 1'b0, "stall_w1");

    // Reset after two refill beats
    core_req_addr = 32'h0000_5104;
    core_req_val  = 1'b1;
    tick();
    tick();
    mem_req_ack = 1'b1;
    tick();
    mem_req_ack   = 1'b0;
    mem_resp_val  = 1'b1;
    mem_resp_data = memval(32'h0000_5100);
    tick();
    mem_resp_data = memval(32'h0000_5104);
    tick();
    mem_resp_val = 1'b0;
    core_req_val = 1'b1;
    tick();
    check("pre_rst_mval", mem_req_val, 1'b0);
    rst_n        = 1'b0;
    core_req_val = 1'b0;
    #1;
    check("midrst_ack",   core_req_ack,  1'b0);
    check("midrst_data",  core_ack_data, 32'h0);
    check("midrst_mval",  mem_req_val,   1'b0);
    check("midrst_maddr", mem_req_addr,  32'h0);
    mem_resp_val  = 1'b1;
    mem_resp_data = 32'hBAD0_0001;
    tick();
    rst_n         = 1'b1;
    mem_resp_data = 32'hBAD0_0002;
    tick();
    mem_resp_val = 1'b0;
    check("postrst_mval", mem_req_val, 1'b0);
    tick();
    fetch(32'h0000_5104, 1'b0, 0, 0, -1, 1'b0, "rst_refetch");
    fetch(32'h0000_5100, 1'b1, 0, 0, -1, 1'b0, "rst_w0");
    fetch(32'h0000_510C, 1'b1, 0, 0, -1, 1'b0, "rst_w3");
    fetch(32'h0000_1000, 1'b0, 0, 0, -1, 1'b0, "rst_cleared");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/l1i_assoc_cache.md
# l1i_assoc_cache

Parametrised, read-only, set-associative L1 instruction cache with its own miss/refill engine. Sits between the core fetch port and the memory/bus side. Lookups are served from flop-based tag and data arrays, and misses fetch a full line as a burst of word beats. Adds configurable ways, sets and line length, round-robin replacement, and a whole-cache invalidate.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, fetch word width; power of 2, ≥ 8
- WAY_NUM, 4, associativity; power of 2, ≥ 1
- SET_NUM, 64, sets per way; power of 2, ≥ 2
- LINE_WORDS, 4, words per line; power of 2, ≥ 2

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- core_req_val  in  1  fetch request; held stable with its address until core_req_ack
- core_req_addr  in  ADDR_WIDTH  fetch byte address; byte-offset bits ignored
- core_req_ack  out  1  one-cycle pulse; request complete, data valid
- core_ack_data  out  DATA_WIDTH  fetched word; valid only while core_req_ack=1
- inv_req  in  1  single-cycle pulse; invalidate whole cache
- mem_req_val  out  1  line refill request
- mem_req_addr  out  ADDR_WIDTH  line-aligned address; low OFF+WSEL bits = 0
- mem_req_ack  in  1  memory accepted request
- mem_resp_val  in  1  one refill beat valid
- mem_resp_data  in  DATA_WIDTH  refill beat, words in ascending address order

## Operation
- Address split, LSB first: OFF = log2(DATA_WIDTH/8) bits, ignored; WSEL = log2(LINE_WORDS); IDX = log2(SET_NUM); TAG = remaining bits.
- Storage: per way, SET_NUM × (valid + TAG) and SET_NUM × LINE_WORDS × DATA_WIDTH. One round-robin victim pointer of log2(WAY_NUM) bits per set.
- FSM states: IDLE, LOOKUP, MREQ, FILL.
- IDLE:
  - If an invalidate is pending: clear all valid bits and all victim pointers this cycle, clear the pending flag, stay in IDLE.
  - Else if core_req_val: capture address, go to LOOKUP.
- LOOKUP: compare TAG against all ways at IDX.
  - Hit (exactly one way): core_req_ack=1, core_ack_data=word WSEL of the hit way, go to IDLE.
  - Miss: victim = pointer[IDX]; go to MREQ.
- MREQ: mem_req_val=1, mem_req_addr={TAG,IDX,0}. On mem_req_ack, go to FILL and reset the beat counter.
- FILL: each mem_resp_val writes mem_resp_data to victim way, word = beat counter, then the counter increments.
  - Gaps between beats are allowed.
  - On the last beat (counter = LINE_WORDS-1): write tag, set valid, pointer[IDX] += 1 mod WAY_NUM, go to LOOKUP. The replayed LOOKUP then hits.
- The victim is chosen by pointer only; invalid ways are not preferred.
- mem_resp_val outside FILL is ignored.
- inv_req in any state sets the pending flag. The flag is serviced only in IDLE, before a new request is accepted. An in-flight request completes and is acked first, and its line is then invalidated.
- inv_req and core_req_val both asserted in IDLE: the invalidate is serviced first, and the request is accepted one cycle later.
- Reset (any state, including mid-FILL) forces the reset values below. A partially filled line stays invalid. The bench must drop stale memory beats; beats arriving after reset are ignored because the FSM is in IDLE.

## Timing
- Reset values: core_req_ack=0, core_ack_data=0, mem_req_val=0, mem_req_addr=0. State IDLE, all valid=0, all pointers=0, pending invalidate=0. The data array is not reset.
- Hit latency: val sampled in cycle N (IDLE), ack in cycle N+1.
- Miss latency: N+1 LOOKUP, N+2 MREQ. If ack arrives in cycle A and the last beat in cycle B, the replay LOOKUP is B+1 and the ack is at B+1. Minimum total is N+2+1+LINE_WORDS, with ack and beats back-to-back.
- mem_req_val and mem_req_addr are stable from MREQ entry until the ack cycle inclusive, and deassert the cycle after ack.
- Back-to-back: after an ack the earliest next ack is 2 cycles later, because IDLE is re-entered.
- Invalidate costs one IDLE cycle.

## Test plan
- Cold miss: default params, read 0x0000_1004.
  - One mem_req_addr=0x0000_1000.
  - Beats D0..D3 are written to the line.
  - core_ack_data=D1 at the replay cycle.
- Hit: then read 0x0000_1000, 0x0000_100C.
  - Acks 1 cycle after sampling with D0 and D3.
  - No mem_req_val.
- Replacement: read 5 distinct tags mapping to IDX 0 (stride 0x400), then re-read the first.
  - Fills go to ways 0,1,2,3,0.
  - Re-reading the first tag misses; rereading tag 2 hits.
- Invalidate: after the fills, pulse inv_req during a FILL.
  - The current request is acked.
  - The next IDLE cycle clears the valid bits, and a reread of the same address issues mem_req.
- Memory stalls: mem_req_ack delayed 5 cycles, 3 idle cycles between beats.
  - mem_req_addr is stable throughout.
  - The line is correct, and the ack follows the last beat by 1 cycle.
- Reset mid-FILL after 2 beats: outputs read 0 immediately. The same request after reset misses and refetches the full line.
